// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter for the APB UART peripheral.
//
// Sends 8-bit bytes LSB first as 8N1 frames on `tx`. A frame carries an even
// parity bit between D7 and the stop bit when the UART_TX_PARITY_EN macro is
// defined. Bit timing comes from the shared 16x oversampling `tick`.
// A one-entry holding register sits in front of the shifter, so software can
// queue the next byte while the current frame is still on the line.
//
// Ports:
//   clk       in   system clock; all logic uses the rising edge
//   rst       in   synchronous, active-high reset
//   tick      in   single-cycle pulse at 16x the baud rate
//   tx_data   in   byte to send; sampled when tx_start is accepted
//   tx_start  in   write strobe; accepted only while tx_ready = 1
//   tx        out  serial line; idles high; driven from a register
//   tx_ready  out  holding register empty (registered)
//   tx_busy   out  FSM is not in IDLE (registered)
//   tx_done   out  one-cycle pulse after the last tick of each stop bit
//
// Configuration macro: UART_TX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t     state_reg, state_next;
  logic [3:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       hold_valid_reg, hold_valid_next;
  logic       tx_reg, tx_next;
  logic       tx_ready_reg;
  logic       tx_busy_reg;
  logic       tx_done_reg, done_next;
  logic       load;
  logic       bit_end;

  // The tick that completes the current 16-tick bit period.
  assign bit_end = tick && (tick_cnt_reg == TICK_LAST);

  always_comb begin
    state_next      = state_reg;
    tick_cnt_next   = tick_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    load            = 1'b0;
    done_next       = 1'b0;

    // The tick counter runs in every active state and wraps 15 -> 0 by itself,
    // so the end of one bit period is also the start of the next.
    if (state_reg != IDLE && tick) begin
      tick_cnt_next = tick_cnt_reg + 4'd1;
    end

    case (state_reg)
      IDLE: begin
        if (hold_valid_reg) begin
          load          = 1'b1;
          tick_cnt_next = 4'd0;
          bit_cnt_next  = 3'd0;
          state_next    = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          done_next = 1'b1;
          // A queued byte starts immediately: no idle gap between frames.
          if (hold_valid_reg) begin
            load          = 1'b1;
            tick_cnt_next = 4'd0;
            bit_cnt_next  = 3'd0;
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      shift_next      = hold_reg;
      hold_valid_next = 1'b0;
    end

    // Acceptance is gated by the registered ready flag. Should it coincide
    // with a load, the old byte has already gone to the shifter above and the
    // new one takes the holding register.
    if (tx_start && tx_ready_reg) begin
      hold_next       = tx_data;
      hold_valid_next = 1'b1;
    end

    // Line level is decoded from the next state so the register output
    // changes on the same edge as the state transition.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_cnt_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = ^shift_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= 4'd0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'd0;
      hold_reg       <= 8'd0;
      hold_valid_reg <= 1'b0;
      tx_reg         <= 1'b1;
      tx_ready_reg   <= 1'b1;
      tx_busy_reg    <= 1'b0;
      tx_done_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tick_cnt_reg   <= tick_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      tx_reg         <= tx_next;
      tx_ready_reg   <= ~hold_valid_next;
      tx_busy_reg    <= (state_next != IDLE);
      tx_done_reg    <= done_next;
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = tx_ready_reg;
  assign tx_busy  = tx_busy_reg;
  assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Table of single-frame vectors (byte, tick spacing, hand-computed line bits),
// plus hand-written sequences for back-to-back/overrun and reset mid-frame.
// Frame bits are stored with bit i = i-th bit on the line (start bit first).
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx, tx_ready, tx_busy, tx_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int tick_div = 1;
  int tick_phase = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  uart_tx #(.OVERSAMPLE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx       (tx),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  // tick changes just after the rising edge and is sampled on the falling edge,
  // so the bench sees exactly the tick value the DUT consumes next edge.
  always @(posedge clk) begin
    #1;
    if (tick_div <= 1) begin
      tick = 1'b1;
    end else begin
      tick_phase = (tick_phase + 1) % tick_div;
      tick = (tick_phase == 0);
    end
  end

  typedef struct {
    logic [7:0] data;
    int         div;
    logic [9:0] frame;  // 8N1 line bits, bit 0 = start bit
    logic       par;    // even parity of data
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] expect_frame(input logic [9:0] f, input logic p);
`ifdef UART_TX_PARITY_EN
    return {f[9], p, f[8:0]};
`else
    if (p) return {1'b0, f};
    return {1'b0, f};
`endif
  endfunction

  // Strobe one byte; returns on the falling edge after the accepting edge.
  // tx_data is scrambled afterwards; it must not affect the queued byte.
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = ~d;
  endtask

  // Walk one frame bit by bit, counting 16 ticks per bit. Returns on the
  // falling edge of the cycle right after the last stop-bit tick.
  task automatic capture_frame(input string tag, input logic [10:0] exp_bits,
                               input int div, input bit wait_fall, input int exp_lat);
    logic [10:0] got = '0;
    int lat = 0;
    int stable_err = 0, busy_err = 0, done_err = 0, dur_err = 0;
    int cyc, ticks;
    logic val;
    if (wait_fall) begin
      while (tx !== 1'b0 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      if (exp_lat >= 0) check({tag, " start latency"}, 32'(lat), 32'(exp_lat));
    end else begin
      check({tag, " no idle gap"}, 32'(tx), 32'd0);
    end
    for (int b = 0; b < NB; b++) begin
      val = tx;
      got[b] = val;
      cyc = 0;
      ticks = 0;
      forever begin
        if (tx !== val) stable_err++;
        if (tx_busy !== 1'b1) busy_err++;
        if (!(b == 0 && cyc == 0) && tx_done !== 1'b0) done_err++;
        cyc++;
        if (tick === 1'b1) ticks++;
        if (ticks == 16 || cyc > 2000) break;
        @(negedge clk);
      end
      if (b == 0) begin
        if (cyc < 15 * div + 1 || cyc > 16 * div) dur_err++;
      end else if (cyc != 16 * div) begin
        dur_err++;
      end
      @(negedge clk);
    end
    check({tag, " line bits"}, 32'(got), 32'(exp_bits));
    check({tag, " bit durations bad"}, 32'(dur_err), 32'd0);
    check({tag, " tx glitches"}, 32'(stable_err), 32'd0);
    check({tag, " busy low in frame"}, 32'(busy_err), 32'd0);
    check({tag, " early tx_done"}, 32'(done_err), 32'd0);
    check({tag, " tx_done pulse"}, 32'(tx_done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    //             data   div  line bits (b9..b0)  parity
    vecs[0] = '{8'hA5, 1, 10'b11_0100_1010, 1'b0};
    vecs[1] = '{8'h07, 1, 10'b10_0000_1110, 1'b1};
    vecs[2] = '{8'h03, 1, 10'b10_0000_0110, 1'b0};
    vecs[3] = '{8'h80, 5, 10'b11_0000_0000, 1'b1};
    vecs[4] = '{8'h00, 1, 10'b10_0000_0000, 1'b0};
    vecs[5] = '{8'hFF, 3, 10'b11_1111_1110, 1'b0};

    // Reset with tick running every cycle.
    rst = 1'b1;
    tick_div = 1;
    repeat (5) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset tx", 32'(tx), 32'd1);
    check("post-reset tx_busy", 32'(tx_busy), 32'd0);
    check("post-reset tx_ready", 32'(tx_ready), 32'd1);

    // Single frames from the table.
    for (int i = 0; i < 6; i++) begin
      tick_div = vecs[i].div;
      repeat (3) @(negedge clk);
      send(vecs[i].data);
      $display("frame %0d: byte 0x%02h, tick every %0d cycles", i, vecs[i].data, vecs[i].div);
      check($sformatf("v%0d accept ready drop", i), 32'(tx_ready), 32'd0);
      capture_frame($sformatf("v%0d", i), expect_frame(vecs[i].frame, vecs[i].par),
                    vecs[i].div, 1'b1, 1);
      check($sformatf("v%0d idle tx", i), 32'(tx), 32'd1);
      check($sformatf("v%0d idle busy", i), 32'(tx_busy), 32'd0);
      check($sformatf("v%0d idle ready", i), 32'(tx_ready), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d done single cycle", i), 32'(tx_done), 32'd0);
    end

    // Back-to-back 0x55 then 0x0F, plus an overrun write of 0xFF.
    tick_div = 1;
    repeat (3) @(negedge clk);
    send(8'h55);
    $display("back-to-back: 0x55, 0x0F, overrun 0xFF");
    check("b2b first accept ready drop", 32'(tx_ready), 32'd0);
    fork
      begin
        capture_frame("b2b 0x55", expect_frame(10'b10_1010_1010, 1'b0), 1, 1'b1, 1);
        capture_frame("b2b 0x0F", expect_frame(10'b10_0001_1110, 1'b0), 1, 1'b0, -1);
      end
      begin
        for (int k = 0; k < 100 && tx_ready !== 1'b1; k++) @(negedge clk);
        check("b2b ready rises", 32'(tx_ready), 32'd1);
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'hEE;
        check("b2b queued ready low", 32'(tx_ready), 32'd0);
        repeat (20) @(negedge clk);
        check("overrun ready low", 32'(tx_ready), 32'd0);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'h00;
      end
    join
    check("b2b end tx idle", 32'(tx), 32'd1);
    check("b2b end busy", 32'(tx_busy), 32'd0);
    check("b2b end ready", 32'(tx_ready), 32'd1);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("overrun byte not sent", 32'(bad), 32'd0);

    // Reset mid-frame during D4 of 0x2F, with 0x81 queued.
    repeat (3) @(negedge clk);
    send(8'h2F);
    $display("reset mid-frame: 0x2F with 0x81 queued");
    bad = 0;
    while (tx !== 1'b0 && bad < 200) begin
      @(negedge clk);
      bad++;
    end
    check("midrst start latency", 32'(bad), 32'd1);
    send(8'h81);
    check("midrst queued ready low", 32'(tx_ready), 32'd0);
    repeat (16 * 5 + 3 - 2) @(negedge clk);
    check("midrst D4 on line", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst tx", 32'(tx), 32'd1);
    check("midrst busy", 32'(tx_busy), 32'd0);
    check("midrst ready", 32'(tx_ready), 32'd1);
    check("midrst done", 32'(tx_done), 32'd0);
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    check("midrst queued byte lost", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
